// File: rtl/key_request_latch8_if.sv
// Handshake bundle between the key conditioning stage and its producer/consumer.
// Signal names follow the encoder-side naming used at the block boundary.
interface key_request_latch8_if;
    logic [7:0] iKey;
    logic       iEn;
    logic       iAckValid;
    logic [2:0] iAckCode;
    logic [7:0] oReq;
    logic       oEI;
    logic [7:0] oStable;
    logic       oOverrun;

    modport slave (
        input  iKey, iEn, iAckValid, iAckCode,
        output oReq, oEI, oStable, oOverrun
    );

    modport master (
        output iKey, iEn, iAckValid, iAckCode,
        input  oReq, oEI, oStable, oOverrun
    );
endinterface

// File: rtl/key_request_latch8.sv
// Synchronizes, debounces and latches eight active-low keys into sticky encoder requests.
// Optional auto-repeat of held keys is enabled by defining KEY_REPEAT_EN.
module key_request_latch8 #(
    parameter int unsigned DEB_CYCLES    = 16,
    parameter int unsigned REPEAT_CYCLES = 1000
) (
    input logic                  iClk,
    input logic                  iRst_n,
    key_request_latch8_if.slave  bus
);
    localparam int unsigned CntW = $clog2(DEB_CYCLES);

    logic [7:0]      s1_q, s1_d;
    logic [7:0]      s2_q, s2_d;
    logic [7:0]      stable_q, stable_d;
    logic [CntW-1:0] cnt_q [8];
    logic [CntW-1:0] cnt_d [8];
    logic [7:0]      req_q, req_d;
    logic            ei_q, ei_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      press;
    logic [7:0]      ack_vec;
    logic [7:0]      tick_vec;
    logic [2:0]      ack_ch;

`ifdef KEY_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_CYCLES);
    logic [RepW-1:0] rep_q, rep_d;
    logic            tick;

    always_comb begin
        tick  = (rep_q == RepW'(REPEAT_CYCLES - 1));
        rep_d = tick ? '0 : rep_q + 1'b1;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) rep_q <= '0;
        else         rep_q <= rep_d;
    end

    // Re-request only channels still held and no longer pending.
    assign tick_vec = tick ? (~stable_q & req_q) : 8'h00;
`else
    assign tick_vec = 8'h00;
`endif

    assign ack_ch = ~bus.iAckCode;

    always_comb begin
        s1_d      = bus.iKey;
        s2_d      = s1_q;
        stable_d  = stable_q;
        press     = 8'h00;
        ack_vec   = 8'h00;
        req_d     = req_q;
        ei_d      = ~bus.iEn;
        if (bus.iAckValid) ack_vec[ack_ch] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntW'(DEB_CYCLES - 1)) begin
                    stable_d[i] = s2_q[i];
                    press[i]    = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            // Priority: press beats ack, ack beats a repeat tick.
            if (press[i])         req_d[i] = 1'b0;
            else if (ack_vec[i])  req_d[i] = 1'b1;
            else if (tick_vec[i]) req_d[i] = 1'b0;
        end
        overrun_d = |(press & ~req_q & ~ack_vec);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s1_q      <= 8'hFF;
            s2_q      <= 8'hFF;
            stable_q  <= 8'hFF;
            req_q     <= 8'hFF;
            ei_q      <= 1'b1;
            overrun_q <= 1'b0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            req_q     <= req_d;
            ei_q      <= ei_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.oReq     = req_q;
    assign bus.oEI      = ei_q;
    assign bus.oStable  = stable_q;
    assign bus.oOverrun = overrun_q;
endmodule

// File: doc/key_request_latch8.md
Name: key_request_latch8

Overview:
- Upstream conditioning stage for the 8-to-3 priority encoder.
- Takes eight raw, bouncy, active-low key/request lines and synchronizes and debounces each one.
- Converts each debounced press into a sticky active-low pending request (oReq) that drives the encoder's iData; oEI drives the encoder's iEI.
- Pending requests clear when the consumer acknowledges them using the encoder's own active-low output code.

Parameters:
- DEB_CYCLES, 16: consecutive stable synchronized samples required to accept a level change; legal range is 2 or more.
- REPEAT_CYCLES, 1000: auto-repeat tick period in clock cycles; used only under KEY_REPEAT_EN; legal range is 2 or more.

Ports:
- iClk  in  1  single clock; all state updates on its rising edge.
- iRst_n  in  1  asynchronous, active-low reset.
- iKey  in  8  raw key lines, active-low (0 = pressed), asynchronous to iClk.
- iEn  in  1  active-high enable for request presentation.
- iAckValid  in  1  one-cycle strobe: the request named by iAckCode has been serviced.
- iAckCode  in  3  active-low channel code, same encoding as the encoder's oData; channel n = ~iAckCode.
- oReq  out  8  pending requests, active-low, registered; connects to encoder iData.
- oEI  out  1  registered, active-low encoder enable.
- oStable  out  8  debounced key levels, active-low, registered.
- oOverrun  out  1  one-cycle pulse: a new press was accepted on a channel that was already pending.

Behaviour:
- Reset (iRst_n = 0, asynchronous):
  - both synchronizer stages = 8'hFF
  - oStable = 8'hFF
  - all debounce counters = 0
  - oReq = 8'hFF
  - oEI = 1
  - oOverrun = 0
  - repeat timer = 0
- Reset asserted mid-debounce or with requests pending discards all state. No request is generated on release unless a key is actually pressed after reset.
- Synchronizer: two flip-flops per bit (s1, s2).
- Debounce, per channel i:
  - mismatch when s2[i] != oStable[i].
  - On mismatch, count increments.
  - When mismatch holds and count == DEB_CYCLES-1: oStable[i] <= s2[i] and count <= 0.
  - When mismatch is absent: count <= 0. A bounce restarts the full count.
  - Counter width is ceil(log2(DEB_CYCLES)); no wrap is possible.
- Latency: iKey[i] changes before edge 0 and is then held. oStable[i] updates at edge DEB_CYCLES+1.
- Press event: occurs at the edge where oStable[i] transitions 1 to 0. At that same edge oReq[i] <= 0. Release (0 to 1) never sets or clears oReq.
- Ack: when iAckValid = 1, oReq[~iAckCode] <= 1 at the next edge.
  - Ack of a channel that is not pending: no effect.
  - Only one channel is cleared per ack.
- Simultaneous press event and ack on the same channel: the set wins; oReq stays 0. oOverrun is not pulsed for this case.
- Press event on a channel whose oReq is already 0 with no ack that cycle: oReq stays 0 and oOverrun = 1 for exactly one cycle. If several channels overrun in one cycle, there is still a single pulse.
- Enable:
  - oEI <= ~iEn, registered, one cycle of latency.
  - oReq keeps accumulating regardless of iEn.
  - Acks are honoured regardless of iEn.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - A shared repeat timer counts 0..REPEAT_CYCLES-1 and wraps; the tick occurs at count REPEAT_CYCLES-1.
  - On a tick, every channel with oStable[i] = 0 and oReq[i] = 1 sets oReq[i] <= 0. A held key therefore re-requests at most once per period after each ack.
  - A tick and an ack on the same channel in the same cycle: the ack is applied; the set is deferred to the next tick.
  - A tick never pulses oOverrun.
  - The timer resets to 0 and runs freely.
- Undefined: no timer logic exists, REPEAT_CYCLES is unused, and a held key produces exactly one request.

Test Plan:
1. Reset value check: DEB_CYCLES = 4, hold iRst_n = 0, then release with iKey = 8'hFF for 20 cycles -> oReq = 8'hFF, oStable = 8'hFF, oEI = 1, oOverrun = 0 throughout.
2. Basic press: drive iKey[5] = 0 and hold; iEn = 1 -> oStable = 8'hDF and oReq = 8'hDF after edge 5; oEI = 0 one cycle after iEn rises. Then iAckValid = 1 with iAckCode = 3'b010 -> oReq = 8'hFF next cycle, while oStable stays 8'hDF.
3. Bounce rejection: iKey[0] toggles 0,1,0,1 with a 2-cycle period, then holds 0 -> no change in oReq until DEB_CYCLES+1 edges after the final hold; oReq = 8'hFE.
4. Multiple pending plus overrun: press keys 7 and 2 (oReq = 8'h7B); release key 7 and press it again without an ack -> one-cycle oOverrun = 1 and oReq stays 8'h7B. Ack code 3'b000 -> oReq = 8'hFB.
5. Set/ack collision: schedule the press event on channel 3 at the same edge as iAckValid = 1 with iAckCode = 3'b100 while oReq[3] = 0 -> oReq[3] stays 0 and oOverrun stays 0.
6. Repeat and reset mid-operation: with KEY_REPEAT_EN and REPEAT_CYCLES = 8, hold key 1 and ack immediately after the press -> oReq[1] is reasserted at the next timer tick, within 8 cycles. Then pulse iRst_n low mid-count -> oReq = 8'hFF immediately (asynchronous); after reset release, oReq[1] asserts again only once the full debounce of the still-held key completes.
